led_panel_driver: RTL and testbench
===================================

LED_PANEL_DRIVER -- requirements
Module: led_panel_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per SHCP/STCP half-period (legal range >= 1).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port frame_data, input, 32 bits: frame for the 4-register panel chain, bits [31:24]=out_D, [23:16]=out_C, [15:8]=out_B, [7:0]=out_A.
REQ-005 SHALL have port frame_valid, input, 1 bit: frame_data is valid.
REQ-006 SHALL have port frame_ready, output, 1 bit: driver can accept a frame.
REQ-007 SHALL have port brightness, input, 4 bits: PWM duty for OE, 0=dark, 15=15/16 on.
REQ-008 SHALL have port DS, output, 1 bit: serial data to the panel.
REQ-009 SHALL have port SHCP, output, 1 bit: shift clock; the panel samples DS on the rising edge.
REQ-010 SHALL have port STCP, output, 1 bit: storage/latch clock; the panel latches on the rising edge.
REQ-011 SHALL have port OE, output, 1 bit: panel output enable, active-low.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a frame has been latched.

Function
REQ-013 All outputs SHALL be registered, and none SHALL glitch.
REQ-014 The FSM SHALL have the states IDLE, SHIFT and LATCH; frame_ready SHALL be 1 only in IDLE.
REQ-015 In IDLE, frame_valid&&frame_ready SHALL capture frame_data into an internal 32-bit register and go to SHIFT on the next edge; frame_data is not sampled at any other time.
REQ-016 SHIFT SHALL last exactly 64*CLK_DIV cycles: 32 bit periods, each with SHCP low for CLK_DIV cycles then high for CLK_DIV cycles.
REQ-017 DS SHALL change only at the first cycle of each SHCP-low phase; bits SHALL be sent MSB first (bit 31 first), so bit 31 ends in out_D[7] after 32 shifts.
REQ-018 LATCH SHALL last exactly 2*CLK_DIV cycles, with STCP high for CLK_DIV cycles then low for CLK_DIV cycles; SHCP=0 and DS=0 in LATCH.
REQ-019 done SHALL pulse on the last LATCH cycle, and the FSM SHALL return to IDLE on the next edge; accept-to-next-accept is at minimum 66*CLK_DIV+1 cycles.
REQ-020 frame_valid asserted outside IDLE SHALL be ignored; a frame held valid is accepted on the first IDLE cycle.
REQ-021 A free-running 4-bit pwm_cnt SHALL increment every clk, wrapping 15->0; OE SHALL be 0 when pwm_cnt < brightness, else 1; brightness is sampled every cycle and is independent of FSM state.
REQ-022 Bit counter and divider counter SHALL be sized for CLK_DIV with no overflow; the bit counter SHALL terminate at exactly 32 SHCP rising edges per frame.

Reset
REQ-023 While rst=0: state=IDLE, DS=0, SHCP=0, STCP=0, OE=1, done=0, frame_ready=0, pwm_cnt=0, and all counters 0.
REQ-024 frame_ready SHALL rise on the first clk edge after rst deasserts.
REQ-025 Reset mid-SHIFT or mid-LATCH SHALL abort immediately with no STCP rising edge, so the panel keeps its previously latched outputs.

Verification (CLK_DIV=2; bench instantiates the panel model LEDPANEL on DS/SHCP/STCP/OE; all bench nets named after ports)
REQ-026 Reset: rst=0 mid-run -> DS=0, SHCP=0, STCP=0, OE=1, done=0, frame_ready=0 within the same cycle; frame_ready=1 one cycle after release.
REQ-027 All-ones frame: frame_data=32'hFFFF_FFFF, brightness=15 -> exactly 32 SHCP rises, 1 STCP rise, done 132 cycles after accept; panel {out_D,out_C,out_B,out_A}=32'hFFFF_FFFF.
REQ-028 Bit order: frame_data=32'hA5C3_0F81 -> out_D=8'hA5, out_C=8'hC3, out_B=8'h0F, out_A=8'h81; DS sampled at the SHCP rises equals bits 31..0 in order.
REQ-029 Back-to-back: frame_valid held high with 32'h1234_5678 then 32'h8765_4321 -> accepts exactly 133 cycles apart; data changed while busy is ignored; the final panel value is 32'h8765_4321.
REQ-030 Mid-frame reset: latch 32'h0000_00FF, start 32'hFFFF_0000, assert rst after the 10th SHCP rise -> no STCP rise, and the panel outputs stay 32'h0000_00FF.
REQ-031 PWM: brightness=4 -> OE=0 for exactly 4 of every 16 cycles; brightness=0 -> OE stays 1; brightness=15 -> OE=1 for exactly 1 of every 16 cycles.

Source files
------------

// File: rtl/led_panel_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : led_panel_driver
// Description : Serialises a 32-bit frame into a 4-register 74HC595-style chain
//               (DS/SHCP/STCP) and PWM-dims the panel through OE.
// Revision    : 1.0 - initial release
// ============================================================================
module led_panel_driver #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] frame_data,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [3:0]  brightness,
    output logic        DS,
    output logic        SHCP,
    output logic        STCP,
    output logic        OE,
    output logic        done
);

    localparam int                 c_div_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);
    localparam logic [4:0]         c_bit_last = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_div_w-1:0] r_div;
    logic               r_phase;
    logic [4:0]         r_bit;
    logic [31:0]        r_shreg;
    logic [3:0]         r_pwm;
    logic               r_ds;
    logic               r_shcp;
    logic               r_stcp;
    logic               r_oe;
    logic               r_done;
    logic               r_ready;

    state_t             w_state_nxt;
    logic [c_div_w-1:0] w_div_nxt;
    logic               w_phase_nxt;
    logic [4:0]         w_bit_nxt;
    logic [31:0]        w_shreg_nxt;
    logic               w_div_end;
    logic [3:0]         w_pwm_nxt;

    assign w_div_end = (r_div == c_div_last);
    assign w_pwm_nxt = r_pwm + 4'd1;

    // r_phase selects the half period: SHCP low/high in SHIFT, STCP high/low in LATCH.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit;
        w_shreg_nxt = r_shreg;
        case (r_state)
            ST_IDLE: begin
                if (frame_valid && r_ready) begin
                    w_state_nxt = ST_SHIFT;
                    w_div_nxt   = '0;
                    w_phase_nxt = 1'b0;
                    w_bit_nxt   = 5'd0;
                    w_shreg_nxt = frame_data;
                end
            end
            ST_SHIFT: begin
                if (w_div_end) begin
                    w_div_nxt = '0;
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                    end else if (r_bit == c_bit_last) begin
                        w_state_nxt = ST_LATCH;
                        w_phase_nxt = 1'b0;
                    end else begin
                        w_bit_nxt   = r_bit + 5'd1;
                        w_phase_nxt = 1'b0;
                        w_shreg_nxt = {r_shreg[30:0], 1'b0};
                    end
                end else begin
                    w_div_nxt = r_div + c_div_one;
                end
            end
            ST_LATCH: begin
                if (w_div_end) begin
                    w_div_nxt = '0;
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_phase_nxt = 1'b0;
                        w_bit_nxt   = 5'd0;
                    end
                end else begin
                    w_div_nxt = r_div + c_div_one;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_div_nxt   = '0;
                w_phase_nxt = 1'b0;
                w_bit_nxt   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_phase <= 1'b0;
            r_bit   <= 5'd0;
            r_shreg <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_phase <= w_phase_nxt;
            r_bit   <= w_bit_nxt;
            r_shreg <= w_shreg_nxt;
        end
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ds    <= 1'b0;
            r_shcp  <= 1'b0;
            r_stcp  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
            r_pwm   <= 4'd0;
            r_oe    <= 1'b1;
        end else begin
            r_ds    <= (w_state_nxt == ST_SHIFT) && w_shreg_nxt[31];
            r_shcp  <= (w_state_nxt == ST_SHIFT) && w_phase_nxt;
            r_stcp  <= (w_state_nxt == ST_LATCH) && !w_phase_nxt;
            r_done  <= (w_state_nxt == ST_LATCH) && w_phase_nxt && (w_div_nxt == c_div_last);
            r_ready <= (w_state_nxt == ST_IDLE);
            r_pwm   <= w_pwm_nxt;
            r_oe    <= !(w_pwm_nxt < brightness);
        end
    end

    assign DS          = r_ds;
    assign SHCP        = r_shcp;
    assign STCP        = r_stcp;
    assign OE          = r_oe;
    assign done        = r_done;
    assign frame_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_led_panel_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_led_panel_driver
// Description : Self-checking bench for led_panel_driver with a behavioural
//               frame-timing model and a shift/latch panel model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_panel_driver;

    localparam int CD      = 2;
    localparam int T_SHIFT = 64 * CD;
    localparam int T_FRAME = 66 * CD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] frame_data = 32'd0;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic [3:0]  brightness = 4'd0;
    logic        DS, SHCP, STCP, OE, done;

    always #5 clk = ~clk;

    led_panel_driver #(.CLK_DIV(CD)) dut (
        .clk(clk), .rst(rst), .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .brightness(brightness), .DS(DS), .SHCP(SHCP),
        .STCP(STCP), .OE(OE), .done(done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Event log observed from the DUT pins: accept and done edges by cycle number.
    int cyc = 0, acc_cnt = 0, done_cnt = 0, acc_at = 0, prev_acc_at = 0, done_at = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && frame_ready && frame_valid) begin
            acc_cnt     <= acc_cnt + 1;
            prev_acc_at <= acc_at;
            acc_at      <= cyc;
        end
        if (rst && done) begin
            done_cnt <= done_cnt + 1;
            done_at  <= cyc;
        end
    end

    // LEDPANEL: four chained shift registers with a storage latch.
    logic [31:0] panel_sr = 32'd0, panel_out = 32'd0;
    int shcp_rises = 0, stcp_rises = 0;
    always @(posedge SHCP) begin
        panel_sr   <= {panel_sr[30:0], DS};
        shcp_rises <= shcp_rises + 1;
    end
    always @(posedge STCP) begin
        panel_out  <= panel_sr;
        stcp_rises <= stcp_rises + 1;
    end

    // Reference: m_d is the cycle offset since accept (1..T_FRAME) while busy.
    logic        m_busy = 1'b0, m_ready = 1'b0, m_oe = 1'b1;
    int          m_d = 0;
    logic [31:0] m_frame = 32'd0;
    logic [3:0]  m_pwm = 4'd0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
            m_d     <= 0;
            m_pwm   <= 4'd0;
            m_oe    <= 1'b1;
        end else begin
            m_pwm <= 4'(m_pwm + 4'd1);
            m_oe  <= !(4'(m_pwm + 4'd1) < brightness);
            if (!m_busy && m_ready && frame_valid) begin
                m_busy  <= 1'b1;
                m_d     <= 1;
                m_frame <= frame_data;
                m_ready <= 1'b0;
            end else if (m_busy) begin
                m_d <= m_d + 1;
                if (m_d == T_FRAME) begin
                    m_busy  <= 1'b0;
                    m_ready <= 1'b1;
                end
            end else begin
                m_ready <= 1'b1;
            end
        end
    end

    // Vector order: {frame_ready, DS, SHCP, STCP, OE, done}
    always @(negedge clk) begin
        logic [5:0] exp_v;
        int k;
        exp_v = {m_ready, 1'b0, 1'b0, 1'b0, m_oe, 1'b0};
        if (!rst) begin
            exp_v = 6'b000010;
        end else if (m_busy && m_d <= T_SHIFT) begin
            k        = m_d - 1;
            exp_v[4] = m_frame[31 - k / (2 * CD)];
            exp_v[3] = (k % (2 * CD)) >= CD;
        end else if (m_busy) begin
            k        = m_d - T_SHIFT - 1;
            exp_v[2] = (k < CD);
            exp_v[0] = (m_d == T_FRAME);
        end
        check("outputs", {26'd0, frame_ready, DS, SHCP, STCP, OE, done}, {26'd0, exp_v});
    end

    task automatic send_frame(input logic [31:0] d, input bit keep_valid);
        int n0;
        int k;
        n0 = acc_cnt;
        frame_data  = d;
        frame_valid = 1'b1;
        k = 0;
        while (acc_cnt == n0 && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!keep_valid) frame_valid = 1'b0;
        check("accept_seen", 32'(acc_cnt != n0), 32'd1);
    endtask

    task automatic wait_done(input bit scramble);
        int n0;
        int k;
        n0 = done_cnt;
        k = 0;
        while (done_cnt == n0 && k < 400) begin
            @(posedge clk);
            #1;
            if (scramble) begin
                frame_valid = 1'($urandom);
                frame_data  = $urandom;
                brightness  = 4'($urandom);
            end
            k++;
        end
        frame_valid = 1'b0;
        check("done_seen", 32'(done_cnt != n0), 32'd1);
    endtask

    task automatic count_oe_low(output int n);
        n = 0;
        repeat (16) begin
            @(negedge clk);
            if (!OE) n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int s0, t0, n;
        logic [31:0] d;

        repeat (3) @(posedge clk);
        #1;
        check("reset_pins", {26'd0, DS, SHCP, STCP, OE, done, frame_ready}, 32'h04);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", frame_ready, 1);

        // All-ones frame at full brightness
        brightness = 4'd15;
        s0 = shcp_rises;
        t0 = stcp_rises;
        send_frame(32'hFFFF_FFFF, 0);
        wait_done(0);
        check("ones_shcp_rises", shcp_rises - s0, 32);
        check("ones_stcp_rises", stcp_rises - t0, 1);
        check("ones_done_latency", done_at - acc_at, 132);
        check("ones_panel", panel_out, 32'hFFFF_FFFF);

        // Bit order
        send_frame(32'hA5C3_0F81, 0);
        wait_done(0);
        check("order_ds_stream", panel_sr, 32'hA5C3_0F81);
        check("order_out_D", panel_out[31:24], 8'hA5);
        check("order_out_C", panel_out[23:16], 8'hC3);
        check("order_out_B", panel_out[15:8], 8'h0F);
        check("order_out_A", panel_out[7:0], 8'h81);

        // Back-to-back with valid held and data disturbed while busy
        send_frame(32'h1234_5678, 1);
        frame_data = 32'hDEAD_BEEF;
        repeat (50) @(posedge clk);
        #1;
        send_frame(32'h8765_4321, 0);
        check("b2b_spacing", acc_at - prev_acc_at, 133);
        wait_done(0);
        check("b2b_panel", panel_out, 32'h8765_4321);

        // PWM duty
        brightness = 4'd4;
        repeat (20) @(posedge clk);
        count_oe_low(n);
        check("pwm_b4_low", n, 4);
        brightness = 4'd0;
        repeat (3) @(posedge clk);
        count_oe_low(n);
        check("pwm_b0_low", n, 0);
        brightness = 4'd15;
        repeat (3) @(posedge clk);
        count_oe_low(n);
        check("pwm_b15_high", 16 - n, 1);

        // Mid-frame reset keeps the previously latched value
        send_frame(32'h0000_00FF, 0);
        wait_done(0);
        check("pre_reset_panel", panel_out, 32'h0000_00FF);
        send_frame(32'hFFFF_0000, 0);
        s0 = shcp_rises;
        n = 0;
        while (shcp_rises < s0 + 10 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ten_rises_seen", shcp_rises - s0, 10);
        t0 = stcp_rises;
        rst = 1'b0;
        @(negedge clk);
        check("midrun_reset_pins", {26'd0, DS, SHCP, STCP, OE, done, frame_ready}, 32'h04);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_midrun", frame_ready, 1);
        repeat (150) @(posedge clk);
        check("abort_no_stcp", stcp_rises - t0, 0);
        check("abort_panel_kept", panel_out, 32'h0000_00FF);

        // Randomised frames, gaps, brightness and ignored valid while busy
        for (int r = 0; r < 12; r++) begin
            brightness = 4'($urandom);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            d = $urandom;
            send_frame(d, 0);
            wait_done(1);
            check("rand_panel", panel_out, d);
        end

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
